// File: rtl/sr_cmd_sequencer.sv
// Command sequencer for an SR flip-flop: queues SET/RESET/TOGGLE/NOP commands,
// drives non-overlapping s/r pulses of programmable width, then checks q.
module sr_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4,
    parameter int ERR_W = 8
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [LEN_W-1:0]           cmd_len,
    input  logic                       q_in,
    output logic                       s,
    output logic                       r,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [ERR_W-1:0]           err_cnt,
    output logic [$clog2(DEPTH):0]     fifo_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_RST = 2'b10;
    localparam logic [1:0] OP_TGL = 2'b11;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    logic [1:0]       op_mem_q  [DEPTH];
    logic [LEN_W-1:0] len_mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;
    state_t           state_q, state_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
    logic             exp_q, exp_d;
    logic             nop_q, nop_d;

    logic             push, pop;
    logic [1:0]       head_op, res_op;
    logic [LEN_W-1:0] head_len;

    assign cmd_ready = (fifo_cnt_q != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && (fifo_cnt_q != '0);
    assign head_op   = op_mem_q[rd_ptr_q];
    assign head_len  = len_mem_q[rd_ptr_q];
    // TOGGLE is resolved against the live q at pop time.
    assign res_op    = (head_op == OP_TGL) ? (q_in ? OP_RST : OP_SET) : head_op;

    always_ff @(posedge clock) begin
        if (push) begin
            op_mem_q[wr_ptr_q]  <= cmd_op;
            len_mem_q[wr_ptr_q] <= cmd_len;
        end
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CW'(1);
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - CW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        s_d       = 1'b0;
        r_d       = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        len_cnt_d = len_cnt_q;
        exp_d     = exp_q;
        nop_d     = nop_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    if (res_op == OP_NOP) begin
                        nop_d   = 1'b1;
                        state_d = CHECK;
                    end else begin
                        nop_d     = 1'b0;
                        exp_d     = (res_op == OP_SET);
                        s_d       = (res_op == OP_SET);
                        r_d       = (res_op == OP_RST);
                        len_cnt_d = (head_len == '0) ? LEN_W'(1) : head_len;
                        state_d   = DRIVE;
                    end
                end
            end
            DRIVE: begin
                // The drive line drops on the edge where the count hits 1.
                if (len_cnt_q == LEN_W'(1)) begin
                    state_d = CHECK;
                end else begin
                    s_d       = s_q;
                    r_d       = r_q;
                    len_cnt_d = len_cnt_q - LEN_W'(1);
                end
            end
            CHECK: begin
                done_d  = 1'b1;
                err_d   = !nop_q && (q_in != exp_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        err_cnt_d = (err_d && (err_cnt_q != '1)) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            state_q    <= IDLE;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            len_cnt_q  <= '0;
            exp_q      <= 1'b0;
            nop_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            state_q    <= state_d;
            s_q        <= s_d;
            r_q        <= r_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            len_cnt_q  <= len_cnt_d;
            exp_q      <= exp_d;
            nop_q      <= nop_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign fifo_cnt = fifo_cnt_q;
    assign busy     = (state_q != IDLE) || (fifo_cnt_q != '0);

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed bench for sr_cmd_sequencer with an SR flop model on q_in.
module tb_sr_cmd_sequencer;

    localparam logic [1:0] NOP = 2'b00, SET = 2'b01, RST = 2'b10, TGL = 2'b11;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_len = 4'd0;
    logic       q_in;
    logic       s, r, busy, done, err;
    logic [7:0] err_cnt;
    logic [2:0] fifo_cnt;

    logic q_sr = 1'b0;
    logic q_mode = 1'b0;
    logic q_force = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int overlap = 0;
    int err_seen = 0;
    int cur = 0;
    int log_q[$];
    int dcyc_q[$];

    sr_cmd_sequencer #(.DEPTH(4), .LEN_W(4), .ERR_W(8)) dut (
        .clock(clock), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .q_in(q_in), .s(s), .r(r), .busy(busy),
        .done(done), .err(err), .err_cnt(err_cnt), .fifo_cnt(fifo_cnt)
    );

    always #5 clock = ~clock;

    assign q_in = q_mode ? q_force : q_sr;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (s) q_sr <= 1'b1;
        else if (r) q_sr <= 1'b0;
    end

    // Per-retirement log: 1 = s pulse, 2 = r pulse, 0 = no drive (NOP).
    always @(negedge clock) begin
        if (!rst_n) begin
            cur = 0;
        end else begin
            if (s && r) overlap++;
            if (s) cur = 1;
            if (r) cur = 2;
            if (done) begin
                log_q.push_back(cur);
                dcyc_q.push_back(cyc);
                cur = 0;
            end
            if (err) err_seen++;
        end
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [3:0] len, output int wait_cyc);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; wait_cyc = 0;
        while (!cmd_ready && wait_cyc < 100) begin step(); wait_cyc++; end
        if (!cmd_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL push_timeout: cmd_ready got 0 want 1 within 100 cycles");
            cmd_valid = 1'b0;
        end else begin
            step();
            acc_cyc = cyc;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin step(); n++; end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_timeout: busy got %b want 0", busy); end
        step(); step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0;
        step(); step();
        n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL rst_s: got %b want 0", s); end
        n_cmp++; if (r !== 1'b0) begin n_fail++; $display("FAIL rst_r: got %b want 0", r); end
        n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_done_err: got %b%b want 00", done, err); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_fifo_cnt: got %0d want 0", fifo_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_set_pulse();
        int w;
        q_mode = 1'b0;
        test_reset();
        push(SET, 4'd3, w);
        n_cmp++; if (fifo_cnt !== 3'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL set_accept: fifo_cnt/busy got %0d/%b want 1/1", fifo_cnt, busy); end
        for (int i = 1; i <= 7; i++) begin
            step();
            n_cmp++; if (s !== (i >= 1 && i <= 3)) begin n_fail++; $display("FAIL set_s_c%0d: got %b want %b", i, s, (i >= 1 && i <= 3)); end
            n_cmp++; if (r !== 1'b0) begin n_fail++; $display("FAIL set_r_c%0d: got %b want 0", i, r); end
            n_cmp++; if (done !== (i == 5)) begin n_fail++; $display("FAIL set_done_c%0d: got %b want %b", i, done, (i == 5)); end
            n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL set_err_c%0d: got %b want 0", i, err); end
        end
    endtask

    task automatic test_fifo_full();
        int w, base;
        int exp_log[6] = '{1, 2, 1, 0, 2, 1};
        q_mode = 1'b0;
        test_reset();
        base = log_q.size();
        push(SET, 4'd15, w);
        step(); step();
        push(RST, 4'd1, w);
        push(SET, 4'd1, w);
        push(NOP, 4'd0, w);
        push(RST, 4'd1, w);
        n_cmp++; if (fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL full_cnt: got %0d want 4", fifo_cnt); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
        push(SET, 4'd2, w);
        n_cmp++; if (w < 1) begin n_fail++; $display("FAIL full_stall: waited %0d cycles want >=1", w); end
        n_cmp++; if (fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL full_refill: got %0d want 4", fifo_cnt); end
        wait_idle(300);
        n_cmp++; if (log_q.size() - base !== 6) begin n_fail++; $display("FAIL full_retired: got %0d want 6", log_q.size() - base); end
        for (int k = 0; k < 6 && base + k < log_q.size(); k++) begin
            n_cmp++; if (log_q[base + k] !== exp_log[k]) begin n_fail++; $display("FAIL full_order_%0d: got %0d want %0d", k, log_q[base + k], exp_log[k]); end
        end
        n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL full_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_toggle();
        int w, sc, rc;
        test_reset();
        q_mode = 1'b1; q_force = 1'b1;
        push(TGL, 4'd0, w);
        sc = 0; rc = 0;
        for (int i = 0; i < 6; i++) begin step(); sc += int'(s); rc += int'(r); end
        n_cmp++; if (rc !== 1) begin n_fail++; $display("FAIL tgl1_r_cycles: got %0d want 1", rc); end
        n_cmp++; if (sc !== 0) begin n_fail++; $display("FAIL tgl1_s_cycles: got %0d want 0", sc); end
        n_cmp++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL tgl1_err_cnt: got %0d want 1", err_cnt); end
        q_force = 1'b0;
        push(TGL, 4'd0, w);
        sc = 0; rc = 0;
        for (int i = 0; i < 6; i++) begin step(); sc += int'(s); rc += int'(r); end
        n_cmp++; if (sc !== 1) begin n_fail++; $display("FAIL tgl0_s_cycles: got %0d want 1", sc); end
        n_cmp++; if (rc !== 0) begin n_fail++; $display("FAIL tgl0_r_cycles: got %0d want 0", rc); end
        n_cmp++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL tgl0_err_cnt: got %0d want 2", err_cnt); end
        q_mode = 1'b0;
    endtask

    task automatic test_err_saturate();
        int w, base_e, base_d;
        test_reset();
        q_mode = 1'b1; q_force = 1'b0;
        base_e = err_seen; base_d = log_q.size();
        for (int k = 0; k < 300; k++) push(SET, 4'd0, w);
        wait_idle(50);
        n_cmp++; if (err_seen - base_e !== 300) begin n_fail++; $display("FAIL sat_err_pulses: got %0d want 300", err_seen - base_e); end
        n_cmp++; if (log_q.size() - base_d !== 300) begin n_fail++; $display("FAIL sat_done_pulses: got %0d want 300", log_q.size() - base_d); end
        n_cmp++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_err_cnt: got %0d want 255", err_cnt); end
        q_mode = 1'b0;
    endtask

    task automatic test_reset_midpulse();
        int w, base, sc;
        q_mode = 1'b0;
        test_reset();
        base = log_q.size();
        push(SET, 4'd8, w);
        push(SET, 4'd2, w);
        push(RST, 4'd2, w);
        push(NOP, 4'd0, w);
        n_cmp++; if (s !== 1'b1 || fifo_cnt !== 3'd3) begin n_fail++; $display("FAIL mid_pre: s/fifo_cnt got %b/%0d want 1/3", s, fifo_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL mid_async_s: got %b want 0", s); end
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL mid_async_cnt: got %0d want 0", fifo_cnt); end
        step(); step();
        rst_n = 1'b1;
        sc = 0;
        for (int i = 0; i < 20; i++) begin step(); sc += int'(s) + int'(r); end
        n_cmp++; if (log_q.size() - base !== 0) begin n_fail++; $display("FAIL mid_done: got %0d want 0", log_q.size() - base); end
        n_cmp++; if (sc !== 0) begin n_fail++; $display("FAIL mid_drive: got %0d want 0", sc); end
        n_cmp++; if (busy !== 1'b0 || fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL mid_post: busy/fifo_cnt got %b/%0d want 0/0", busy, fifo_cnt); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_back_to_back();
        int w, base, a0, ov0;
        int exp_log[4] = '{0, 1, 2, 0};
        int exp_gap[4] = '{2, 4, 3, 2};
        int got;
        q_mode = 1'b0;
        test_reset();
        base = log_q.size(); ov0 = overlap;
        push(NOP, 4'd0, w); a0 = acc_cyc;
        push(SET, 4'd2, w);
        push(RST, 4'd1, w);
        push(NOP, 4'd0, w);
        wait_idle(100);
        n_cmp++; if (log_q.size() - base !== 4) begin n_fail++; $display("FAIL b2b_retired: got %0d want 4", log_q.size() - base); end
        for (int k = 0; k < 4 && base + k < log_q.size(); k++) begin
            n_cmp++; if (log_q[base + k] !== exp_log[k]) begin n_fail++; $display("FAIL b2b_order_%0d: got %0d want %0d", k, log_q[base + k], exp_log[k]); end
            got = dcyc_q[base + k] - ((k == 0) ? a0 : dcyc_q[base + k - 1]);
            n_cmp++; if (got !== exp_gap[k]) begin n_fail++; $display("FAIL b2b_gap_%0d: got %0d want %0d", k, got, exp_gap[k]); end
        end
        n_cmp++; if (overlap - ov0 !== 0) begin n_fail++; $display("FAIL b2b_overlap: got %0d want 0", overlap - ov0); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL b2b_err_cnt: got %0d want 0", err_cnt); end
    endtask

    initial begin
        #1;
        test_reset();
        test_set_pulse();
        test_fifo_full();
        test_toggle();
        test_err_saturate();
        test_reset_midpulse();
        test_back_to_back();
        n_cmp++; if (overlap !== 0) begin n_fail++; $display("FAIL s_r_overlap_total: got %0d want 0", overlap); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
